data_mem_responder: RTL and testbench

Memory-side responder for the processor's data port: accepts one load/store request at a time over a valid/ready handshake, services it from a 32 × 64-bit register array after a programmable number of wait states, and returns read data or a write acknowledge over a second valid/ready handshake. It sits between the processor datapath (initiator) and the data storage, and replaces the zero-wait combinational data path so the control unit can be exercised against real memory latency and backpressure.

---
 rtl/data_mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Memory-side responder for the processor data port. Accepts one
//             load/store at a time over a valid/ready request handshake,
//             services it from a (2^ADDR_W) x DATA_W register array after
//             LATENCY wait states, and returns read data (or, for stores, the
//             data written) over a valid/ready response handshake.
//  Ports    : clk         - clock, all state changes on rising edge
//             reset       - synchronous active-low reset
//             req_valid   - initiator presents a request
//             req_ready   - responder can accept a request this cycle
//             req_we      - 1 = store, 0 = load
//             req_addr    - word address
//             req_wdata   - store data
//             resp_valid  - response available
//             resp_ready  - initiator consumes response this cycle
//             resp_we     - echo of the answered transaction's req_we
//             resp_rdata  - load data, or store data for stores
//  Params   : ADDR_W (word address width), DATA_W (word width),
//             LATENCY (wait-state cycles, legal range 0..15)
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_we,
    output logic [DATA_W-1:0] resp_rdata
);

    localparam int         c_depth    = 1 << ADDR_W;
    localparam logic [3:0] c_latency  = 4'(LATENCY);
    localparam bit         c_zero_lat = (LATENCY == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_req_ready;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_resp_we;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic [DATA_W-1:0]   r_mem [0:c_depth-1];

    logic                w_accept;
    logic                w_access;
    logic                w_resp_valid;
    logic                w_acc_we;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic [DATA_W-1:0]   w_acc_wdata;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and decoded control
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept = 1'b1;
                    if (c_zero_lat) begin
                        // Zero wait states: the access happens on the
                        // accept edge itself.
                        w_access     = 1'b1;
                        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_access     = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The access uses the live request fields when it happens on the accept
    // edge (zero latency) and the latched copy otherwise.
    always_comb begin
        w_acc_we    = r_we;
        w_acc_addr  = r_addr;
        w_acc_wdata = r_wdata;
        if (r_state == S_IDLE) begin
            w_acc_we    = req_we;
            w_acc_addr  = req_addr;
            w_acc_wdata = req_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Registered request-ready: high exactly while the FSM sits in IDLE with
    // reset released, and never combinationally dependent on an input.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_req_ready <= 1'b0;
        end else begin
            r_req_ready <= (w_state_next == S_IDLE);
        end
    end

    // ------------------------------------------------------------------------
    // Wait counter and request latch
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= c_latency;
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response registers: loaded only by an access, so they hold steady for
    // as long as the initiator applies backpressure in RESP.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_resp_we    <= 1'b0;
            r_resp_rdata <= '0;
        end else if (w_access) begin
            r_resp_we    <= w_acc_we;
            r_resp_rdata <= w_acc_we ? w_acc_wdata : r_mem[w_acc_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Storage array; reset clears every word, and an in-flight store that has
    // not reached its access edge is simply never committed.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_access && w_acc_we) begin
            r_mem[w_acc_addr] <= w_acc_wdata;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = w_resp_valid;
    assign resp_we    = r_resp_we;
    assign resp_rdata = r_resp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Directed self-checking bench. Two responders share clk/reset:
//             u_lat2 (LATENCY = 2) and u_lat0 (LATENCY = 0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk;
    logic        reset;

    logic        a_req_valid, a_req_ready, a_req_we;
    logic [4:0]  a_req_addr;
    logic [63:0] a_req_wdata;
    logic        a_resp_valid, a_resp_ready, a_resp_we;
    logic [63:0] a_resp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [4:0]  b_req_addr;
    logic [63:0] b_req_wdata;
    logic        b_resp_valid, b_resp_ready, b_resp_we;
    logic [63:0] b_resp_rdata;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(.ADDR_W(5), .DATA_W(64), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_we(a_resp_we), .resp_rdata(a_resp_rdata)
    );

    data_mem_responder #(.ADDR_W(5), .DATA_W(64), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_we(b_resp_we), .resp_rdata(b_resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction on the LATENCY = 2 instance, with resp_ready held low
    // for hold_k cycles once the response is visible.
    task automatic txn2(input logic we, input logic [4:0] addr, input logic [63:0] wdata,
                        input int hold_k, input logic [63:0] exp_rdata);
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
        a_resp_ready = 1'b0;
        tick();                         // accept edge N
        a_req_valid = 1'b0;
        check("l2_ready_after_accept", a_req_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            check("l2_valid_during_wait", a_resp_valid, 1'b0);
            tick();
        end
        check("l2_resp_valid", a_resp_valid, 1'b1);
        check("l2_resp_we", a_resp_we, we);
        check("l2_resp_rdata", a_resp_rdata, exp_rdata);
        for (int k = 0; k < hold_k; k++) begin
            tick();
            check("l2_hold_valid", a_resp_valid, 1'b1);
            check("l2_hold_rdata", a_resp_rdata, exp_rdata);
            check("l2_hold_ready", a_req_ready, 1'b0);
        end
        a_resp_ready = 1'b1;
        tick();                         // handshake edge M
        a_resp_ready = 1'b0;
        check("l2_valid_after_hs", a_resp_valid, 1'b0);
        check("l2_ready_after_hs", a_req_ready, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b0;

        // Reset held for 3 cycles
        tick(); tick(); tick();
        check("rst_req_ready", a_req_ready, 1'b0);
        check("rst_resp_valid", a_resp_valid, 1'b0);
        check("rst_resp_we", a_resp_we, 1'b0);
        check("rst_resp_rdata", a_resp_rdata, 64'h0);
        check("rst0_req_ready", b_req_ready, 1'b0);
        check("rst0_resp_valid", b_resp_valid, 1'b0);
        reset = 1'b1;
        tick();
        check("rel_req_ready", a_req_ready, 1'b1);
        check("rel0_req_ready", b_req_ready, 1'b1);

        // Load of a never-written word after reset
        txn2(1'b0, 5'd7, 64'h0, 0, 64'h0);

        // Store then load, LATENCY = 2
        txn2(1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF);
        txn2(1'b0, 5'd5, 64'h0, 0, 64'h0123_4567_89AB_CDEF);

        // Backpressure: 4 cycles of resp_ready low
        txn2(1'b1, 5'd3, 64'hAA, 0, 64'hAA);
        txn2(1'b0, 5'd3, 64'h0, 4, 64'hAA);

        // Top address is an ordinary word
        txn2(1'b1, 5'd31, 64'hFEED_FACE_0000_0031, 0, 64'hFEED_FACE_0000_0031);
        txn2(1'b0, 5'd31, 64'h0, 0, 64'hFEED_FACE_0000_0031);
        txn2(1'b0, 5'd5, 64'h0, 0, 64'h0123_4567_89AB_CDEF);

        // Request while busy is ignored
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 5'd5; a_req_wdata = '0;
        tick();                         // accept load of addr 5
        a_req_we = 1'b1; a_req_addr = 5'd9; a_req_wdata = 64'hDEAD_BEEF;
        check("busy_valid_w1", a_resp_valid, 1'b0);
        tick();
        check("busy_valid_w2", a_resp_valid, 1'b0);
        tick();
        check("busy_resp_valid", a_resp_valid, 1'b1);
        check("busy_resp_we", a_resp_we, 1'b0);
        check("busy_resp_rdata", a_resp_rdata, 64'h0123_4567_89AB_CDEF);
        tick();                         // store still presented during RESP
        check("busy_ready_resp", a_req_ready, 1'b0);
        a_req_valid = 1'b0; a_resp_ready = 1'b1;
        tick();
        a_resp_ready = 1'b0;
        check("busy_done_valid", a_resp_valid, 1'b0);
        tick();
        check("busy_no_extra", a_resp_valid, 1'b0);
        txn2(1'b0, 5'd9, 64'h0, 0, 64'h0);

        // Reset during WAIT drops an in-flight store
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 5'd12; a_req_wdata = 64'hFFFF;
        tick();                         // accept
        a_req_valid = 1'b0;
        reset = 1'b0;
        tick();
        check("midrst_valid1", a_resp_valid, 1'b0);
        check("midrst_ready1", a_req_ready, 1'b0);
        tick(); tick();
        check("midrst_valid3", a_resp_valid, 1'b0);
        check("midrst_rdata", a_resp_rdata, 64'h0);
        reset = 1'b1;
        tick();
        check("midrst_rel_ready", a_req_ready, 1'b1);
        check("midrst_rel_valid", a_resp_valid, 1'b0);
        txn2(1'b0, 5'd12, 64'h0, 0, 64'h0);
        txn2(1'b0, 5'd5, 64'h0, 0, 64'h0);
        txn2(1'b0, 5'd7, 64'h0, 0, 64'h0);

        // LATENCY = 0, resp_ready tied high, req_valid held continuously.
        b_resp_ready = 1'b1;
        b_req_valid  = 1'b1;
        for (int a = 0; a < 32; a++) begin
            b_req_we = 1'b1; b_req_addr = 5'(a); b_req_wdata = 64'(a * 3);
            tick();                     // accept + access
            check("l0_st_valid", b_resp_valid, 1'b1);
            check("l0_st_we", b_resp_we, 1'b1);
            check("l0_st_rdata", b_resp_rdata, 64'(a * 3));
            check("l0_st_ready", b_req_ready, 1'b0);
            tick();                     // handshake
            check("l0_st_idle_valid", b_resp_valid, 1'b0);
            check("l0_st_idle_ready", b_req_ready, 1'b1);
        end
        for (int a = 0; a < 32; a++) begin
            b_req_we = 1'b0; b_req_addr = 5'(a); b_req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
            tick();
            check("l0_ld_valid", b_resp_valid, 1'b1);
            check("l0_ld_we", b_resp_we, 1'b0);
            check("l0_ld_rdata", b_resp_rdata, 64'(a * 3));
            tick();
            check("l0_ld_idle_valid", b_resp_valid, 1'b0);
        end
        b_req_valid = 1'b0;
        tick();
        check("l0_quiet", b_resp_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
